poly_aead_seq: RTL

Sequencer that drives the Poly1305 tag engine for ChaCha20-Poly1305 AEAD MAC input construction (RFC 8439 §2.8). It receives AAD and ciphertext bytes as 128-bit blocks from an upstream stream and zero-pads each segment to a 16-byte boundary. It appends the 16-byte length block, computes the padded total length, and answers the tag engine's block requests. It sits between the cipher datapath and the tag engine and returns the final 128-bit tag.

---
 rtl/poly_aead_seq.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/poly_aead_seq.sv
// ============================================================================
// poly_aead_seq : frames AAD / ciphertext / length blocks for a Poly1305 tag
// engine (ChaCha20-Poly1305 AEAD MAC input) and returns the final tag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module poly_aead_seq (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_start,
    input  logic [63:0]  i_aad_len,
    input  logic [63:0]  i_ct_len,
    input  logic         i_blk_valid,
    input  logic [127:0] i_blk_data,
    output logic         o_blk_ready,
    output logic         o_pt_start,
    output logic         o_pt_en_msg,
    output logic [127:0] o_pt_msg,
    output logic [64:0]  o_pt_len_msg,
    input  logic         i_pt_rqst_msg,
    input  logic         i_pt_done,
    input  logic [127:0] i_pt_tag,
    output logic [127:0] o_tag,
    output logic         o_done,
    output logic         o_busy,
    output logic         o_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_START     = 3'd2,
        S_WAIT_RQ   = 3'd3,
        S_FEED      = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t       state_q, state_d;
    logic [63:0]  aad_rem_q, aad_rem_d, ct_rem_q, ct_rem_d;
    logic [63:0]  aad_len_q, aad_len_d, ct_len_q, ct_len_d;
    logic         first_q, first_d, is_len_q, is_len_d;
    logic         last_sent_q, last_sent_d, pend_q, pend_d;
    logic         err_q, err_d, start_q, start_d, en_q, en_d;
    logic [127:0] msg_q, msg_d, tag_q, tag_d;
    logic [64:0]  len_q, len_d;

    logic         seg_aad, seg_ct, hs;
    logic [63:0]  rem;
    logic [4:0]   nbytes;
    logic [127:0] masked;

    function automatic logic [64:0] pad16(input logic [63:0] x);
        logic [64:0] s;
        s = {1'b0, x} + 65'd15;
        return {s[64:4], 4'b0000};
    endfunction

    // Current segment and the byte mask for a partial final block
    always_comb begin
        seg_aad = (aad_rem_q != 64'd0);
        seg_ct  = !seg_aad && (ct_rem_q != 64'd0);
        rem     = seg_aad ? aad_rem_q : ct_rem_q;
        nbytes  = (|rem[63:4]) ? 5'd16 : {1'b0, rem[3:0]};
        masked  = '0;
        for (int k = 0; k < 16; k++) begin
            masked[8*k +: 8] = (k < int'(nbytes)) ? i_blk_data[8*k +: 8] : 8'h00;
        end
        o_blk_ready = (state_q == S_FETCH) && (seg_aad || seg_ct);
        hs          = o_blk_ready && i_blk_valid;
    end

    always_comb begin
        state_d     = state_q;
        aad_rem_d   = aad_rem_q;
        ct_rem_d    = ct_rem_q;
        aad_len_d   = aad_len_q;
        ct_len_d    = ct_len_q;
        first_d     = first_q;
        is_len_d    = is_len_q;
        last_sent_d = last_sent_q;
        pend_d      = pend_q | i_pt_rqst_msg;
        err_d       = err_q;
        start_d     = 1'b0;
        en_d        = 1'b0;
        msg_d       = msg_q;
        tag_d       = tag_q;
        len_d       = len_q;

        if (state_q != S_IDLE) begin
            if ((i_pt_rqst_msg && last_sent_q) || (i_pt_done && !last_sent_q)) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    aad_rem_d   = i_aad_len;
                    ct_rem_d    = i_ct_len;
                    aad_len_d   = i_aad_len;
                    ct_len_d    = i_ct_len;
                    len_d       = pad16(i_aad_len) + pad16(i_ct_len) + 65'd16;
                    first_d     = 1'b1;
                    last_sent_d = 1'b0;
                    err_d       = 1'b0;
                    pend_d      = 1'b0;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (seg_aad || seg_ct) begin
                    if (hs) begin
                        msg_d    = masked;
                        is_len_d = 1'b0;
                        if (seg_aad) aad_rem_d = aad_rem_q - {59'd0, nbytes};
                        else         ct_rem_d  = ct_rem_q - {59'd0, nbytes};
                        first_d  = 1'b0;
                        state_d  = first_q ? S_START : S_FEED;
                    end
                end else begin
                    msg_d    = {ct_len_q, aad_len_q};
                    is_len_d = 1'b1;
                    first_d  = 1'b0;
                    state_d  = first_q ? S_START : S_FEED;
                end
            end
            S_START: begin
                start_d     = 1'b1;
                last_sent_d = is_len_q;
                state_d     = S_WAIT_RQ;
            end
            S_FEED: begin
                en_d        = 1'b1;
                last_sent_d = is_len_q;
                state_d     = S_WAIT_RQ;
            end
            S_WAIT_RQ: begin
                if (last_sent_q) begin
                    if (i_pt_done) begin
                        tag_d   = i_pt_tag;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_DONE;
                    end
                end else if (pend_q || i_pt_rqst_msg) begin
                    pend_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_WAIT_DONE: begin
                if (i_pt_done) begin
                    tag_d   = i_pt_tag;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            aad_rem_q   <= '0;
            ct_rem_q    <= '0;
            aad_len_q   <= '0;
            ct_len_q    <= '0;
            first_q     <= 1'b0;
            is_len_q    <= 1'b0;
            last_sent_q <= 1'b0;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            en_q        <= 1'b0;
            msg_q       <= '0;
            tag_q       <= '0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            aad_rem_q   <= aad_rem_d;
            ct_rem_q    <= ct_rem_d;
            aad_len_q   <= aad_len_d;
            ct_len_q    <= ct_len_d;
            first_q     <= first_d;
            is_len_q    <= is_len_d;
            last_sent_q <= last_sent_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            start_q     <= start_d;
            en_q        <= en_d;
            msg_q       <= msg_d;
            tag_q       <= tag_d;
            len_q       <= len_d;
        end
    end

    assign o_pt_start   = start_q;
    assign o_pt_en_msg  = en_q;
    assign o_pt_msg     = msg_q;
    assign o_pt_len_msg = len_q;
    assign o_tag        = tag_q;
    assign o_done       = (state_q == S_DONE);
    assign o_busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_err        = err_q;

endmodule

`default_nettype wire
